// File: rtl/text_renderer.sv
// Character-cell text renderer: pixel coords -> text buffer -> font ROM -> RGB, 3-cycle pipeline.
// Optional blinking underline cursor is built when TEXT_RENDERER_CURSOR_EN is defined.
module text_renderer #(
  parameter int                   H_CHARS    = 80,
  parameter int                   V_CHARS    = 30,
  parameter int                   ADDR_W     = 12,
  parameter int                   COLOR_W    = 4,
  parameter logic [3*COLOR_W-1:0] FG_COLOR   = 12'hFFF,
  parameter logic [3*COLOR_W-1:0] BG_COLOR   = 12'h000,
  parameter int                   BLINK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               video_on_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [ADDR_W-1:0]  char_addr,
  input  logic [7:0]         char_code,
  output logic [10:0]        font_addr,
  input  logic [7:0]         font_data,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de_out
);

  typedef struct packed {
    logic [3:0] grow;
    logic [2:0] bx;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       area;
  } s1_t;

  typedef struct packed {
    logic [2:0] bx;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       area;
    logic       inv;
  } s2_t;

  // Syncs idle high through the pipe so reset release never emits a false sync pulse.
  localparam s1_t S1_RST = '{grow: 4'd0, bx: 3'd0, vo: 1'b0, hs: 1'b1, vs: 1'b1, area: 1'b0};
  localparam s2_t S2_RST = '{bx: 3'd0, vo: 1'b0, hs: 1'b1, vs: 1'b1, area: 1'b0, inv: 1'b0};

  logic [6:0]           col;
  logic [5:0]           row;
  s1_t                  s1_d, s1_q;
  s2_t                  s2_d, s2_q;
  logic                 pix, fg_sel, cur_hit;
  logic [3*COLOR_W-1:0] rgb_d, rgb_q;
  logic                 hs_q, vs_q, de_q;

  // Stage 0: cell address
  assign col       = pixel_x[9:3];
  assign row       = pixel_y[9:4];
  assign char_addr = ADDR_W'(row) * ADDR_W'(H_CHARS) + ADDR_W'(col);

  always_comb begin
    s1_d      = S1_RST;
    s1_d.grow = pixel_y[3:0];
    s1_d.bx   = pixel_x[2:0];
    s1_d.vo   = video_on_in;
    s1_d.hs   = hsync_in;
    s1_d.vs   = vsync_in;
    s1_d.area = (32'(col) < H_CHARS) && (32'(row) < V_CHARS);
  end

  // Stage 1: glyph row fetch
  assign font_addr = {char_code[6:0], s1_q.grow};

  always_comb begin
    s2_d      = S2_RST;
    s2_d.bx   = s1_q.bx;
    s2_d.vo   = s1_q.vo;
    s2_d.hs   = s1_q.hs;
    s2_d.vs   = s1_q.vs;
    s2_d.area = s1_q.area;
    s2_d.inv  = char_code[7];
  end

`ifdef TEXT_RENDERER_CURSOR_EN
  logic [BLINK_LOG2:0] frame_q;
  logic                vs_dly_q;
  logic [12:0]         cell1_q;   // {col, row}
  logic [16:0]         cell2_q;   // {col, row, glyph_row}

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q  <= '0;
      vs_dly_q <= 1'b1;
      cell1_q  <= '0;
      cell2_q  <= '0;
    end else begin
      vs_dly_q <= vsync_in;
      if (vs_dly_q && !vsync_in) frame_q <= frame_q + (BLINK_LOG2+1)'(1);
      cell1_q  <= {col, row};
      cell2_q  <= {cell1_q, s1_q.grow};
    end
  end

  assign cur_hit = (cell2_q[16:10] == cursor_col) && (cell2_q[9:4] == {1'b0, cursor_row}) &&
                   ((cell2_q[3:0] == 4'd13) || (cell2_q[3:0] == 4'd14)) && frame_q[BLINK_LOG2];
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row};
  assign cur_hit       = 1'b0;
`endif

  // Stage 2: serialize; 7-bx == ~bx for a 3-bit index
  always_comb begin
    pix    = font_data[~s2_q.bx];
    fg_sel = (s2_q.area & (pix ^ s2_q.inv)) | cur_hit;
    rgb_d  = '0;
    if (s2_q.vo) rgb_d = fg_sel ? FG_COLOR : BG_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= S1_RST;
      s2_q  <= S2_RST;
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      rgb_q <= rgb_d;
      hs_q  <= s2_q.hs;
      vs_q  <= s2_q.vs;
      de_q  <= s2_q.vo;
    end
  end

  assign red       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign green     = rgb_q[2*COLOR_W-1:COLOR_W];
  assign blue      = rgb_q[COLOR_W-1:0];
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign de_out    = de_q;

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: behavioural text buffer and font ROM, table-driven pixel vectors.
module tb_text_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on_in, hsync_in, vsync_in;
  logic [11:0] char_addr;
  logic [7:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [3:0]  red, green, blue;
  logic        hsync_out, vsync_out, de_out;

  int n_cmp = 0;
  int n_err = 0;

  text_renderer #(.BLINK_LOG2(1)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .char_addr(char_addr), .char_code(char_code), .font_addr(font_addr), .font_data(font_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );

  always #5 clk = ~clk;

  // Text buffer and font ROM: 1-cycle read latency each
  logic [7:0] tbuf [0:4095];
  always @(posedge clk) begin
    char_code <= tbuf[char_addr];
    font_data <= (font_addr == 11'd1043) ? 8'b00011000 : 8'h00;
  end

  typedef struct {
    logic [9:0]  x, y;
    logic        vo, hs, vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int x, int y, bit vo, bit hs, bit vs, logic [11:0] rgb);
    vec_t v;
    v.x = 10'(x); v.y = 10'(y); v.vo = vo; v.hs = hs; v.vs = vs; v.rgb = rgb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " rgb"}, {20'd0, red, green, blue}, 32'h0);
    check({tag, " de"}, {31'd0, de_out}, 32'd0);
    check({tag, " hs"}, {31'd0, hsync_out}, 32'd1);
    check({tag, " vs"}, {31'd0, vsync_out}, 32'd1);
  endtask

  task automatic drive(input vec_t v);
    pixel_x = v.x; pixel_y = v.y; video_on_in = v.vo; hsync_in = v.hs; vsync_in = v.vs;
  endtask

  task automatic pix_check(input string name, input int x, input int y, input logic [11:0] exp);
    @(negedge clk);
    drive(mk(x, y, 1'b1, 1'b1, 1'b1, 12'h0));
    repeat (3) @(negedge clk);
    check(name, {20'd0, red, green, blue}, {20'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(0, 0, 1'b0, 1'b1, 1'b1, 12'h0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic hs_a [0:199];
  logic vo_a [0:199];

  initial begin
    for (int i = 0; i < 4096; i++) tbuf[i] = 8'h00;
    tbuf[0]    = 8'h41;
    tbuf[1]    = 8'hC1;
    tbuf[80]   = 8'hC1;
    tbuf[162]  = 8'h41;
    tbuf[2400] = 8'hC1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    rst_n      = 1'b0;
    drive(mk(0, 0, 1'b0, 1'b1, 1'b1, 12'h0));

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pixel_x = 10'($urandom); pixel_y = 10'($urandom);
      video_on_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      check_idle("reset_hold");
    end

    // Release mid-line: first real output after the 3rd rising edge
    @(negedge clk);
    drive(mk(3, 3, 1'b1, 1'b0, 1'b1, 12'h0));
    rst_n = 1'b1;
    @(negedge clk); check_idle("post_rel_e1");
    @(negedge clk); check_idle("post_rel_e2");
    @(negedge clk);
    check("post_rel_e3 rgb", {20'd0, red, green, blue}, 32'hFFF);
    check("post_rel_e3 hs", {31'd0, hsync_out}, 32'd0);
    check("post_rel_e3 de", {31'd0, de_out}, 32'd1);

    // Pixel vectors: 'A' row 3 = 00011000, inverse cell, blanking, out-of-area
    for (int x = 0; x < 8; x++)  vt.push_back(mk(x, 3, 1, 1, 1, (x == 3 || x == 4) ? 12'hFFF : 12'h000));
    for (int x = 8; x < 16; x++) vt.push_back(mk(x, 3, 1, x[0], 1, (x == 11 || x == 12) ? 12'h000 : 12'hFFF));
    vt.push_back(mk(17, 35, 1, 1, 0, 12'h000));
    vt.push_back(mk(19, 35, 1, 1, 0, 12'hFFF));
    vt.push_back(mk(20, 35, 1, 0, 0, 12'hFFF));
    vt.push_back(mk(3, 3, 0, 1, 1, 12'h000));
    vt.push_back(mk(640, 3, 1, 1, 1, 12'h000));
    vt.push_back(mk(0, 480, 1, 1, 1, 12'h000));
    vt.push_back(mk(3, 4, 1, 1, 1, 12'h000));
    vt.push_back(mk(10, 4, 1, 1, 1, 12'hFFF));
    for (int j = 0; j < vt.size() + 3; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        check($sformatf("vec%0d rgb x=%0d y=%0d", j-3, vt[j-3].x, vt[j-3].y),
              {20'd0, red, green, blue}, {20'd0, vt[j-3].rgb});
        check($sformatf("vec%0d de", j-3), {31'd0, de_out}, {31'd0, vt[j-3].vo});
        check($sformatf("vec%0d hs", j-3), {31'd0, hsync_out}, {31'd0, vt[j-3].hs});
        check($sformatf("vec%0d vs", j-3), {31'd0, vsync_out}, {31'd0, vt[j-3].vs});
      end
      if (j < vt.size()) drive(vt[j]);
      else drive(mk(0, 0, 0, 1, 1, 12'h0));
    end

    // Addressing: (17,35) -> 162, then 'A' glyph row 3 -> 1043
    @(negedge clk);
    drive(mk(17, 35, 1, 1, 1, 12'h0));
    #1 check("char_addr", {20'd0, char_addr}, 32'd162);
    @(posedge clk); #1;
    check("font_addr", {21'd0, font_addr}, 32'd1043);

    // 96-cycle hsync pulse and 40-cycle DE gap, each delayed by 3
    for (int c = 0; c < 200; c++) begin
      hs_a[c] = !(c >= 50 && c < 146);
      vo_a[c] = !(c >= 20 && c < 60);
    end
    for (int c = 0; c < 203; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check($sformatf("hs_align c=%0d", c-3), {31'd0, hsync_out}, {31'd0, hs_a[c-3]});
        check($sformatf("de_align c=%0d", c-3), {31'd0, de_out}, {31'd0, vo_a[c-3]});
      end
      if (c < 200) drive(mk(c, 3, vo_a[c], hs_a[c], 1, 12'h0));
      else drive(mk(0, 0, 0, 1, 1, 12'h0));
    end

`ifdef TEXT_RENDERER_CURSOR_EN
    // Blink: frame_cnt[1] set for frames 2,3 of every 4
    do_reset();
    for (int f = 0; f < 8; f++) begin
      logic [11:0] e;
      e = f[1] ? 12'hFFF : 12'h000;
      pix_check($sformatf("cursor f%0d y45", f), 40, 45, e);
      pix_check($sformatf("cursor f%0d y46", f), 47, 46, e);
      pix_check($sformatf("cursor f%0d y47", f), 44, 47, 12'h000);
      pix_check($sformatf("cursor f%0d nbr", f), 48, 45, 12'h000);
      @(negedge clk); vsync_in = 1'b0;
      @(negedge clk); @(negedge clk); vsync_in = 1'b1;
      @(negedge clk);
    end
`else
    do_reset();
    pix_check("nocursor y45", 40, 45, 12'h000);
`endif

    // Asynchronous reset between edges
    @(negedge clk);
    drive(mk(3, 3, 1, 0, 0, 12'h0));
    repeat (3) @(negedge clk);
    check("pre_async rgb", {20'd0, red, green, blue}, 32'hFFF);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk); rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
